// File: rtl/hit_scan_pkg.sv
// ============================================================================
// Package  : hit_scan_pkg
// Purpose  : State encodings, flag bit positions and defaults for the scan sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hit_scan_pkg;

   localparam int DEFAULT_COUNT_W = 20;

   localparam int FLAG_TIMEOUT = 0;
   localparam int FLAG_SAT     = 1;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_SETTLE     = 3'd1;
   localparam logic [2:0] ST_START      = 3'd2;
   localparam logic [2:0] ST_ARM_WAIT   = 3'd3;
   localparam logic [2:0] ST_COUNT_WAIT = 3'd4;
   localparam logic [2:0] ST_EMIT       = 3'd5;
   localparam logic [2:0] ST_DONE       = 3'd6;

endpackage

`default_nettype wire

// File: rtl/hit_scan_timer.sv
// ============================================================================
// Module   : hit_scan_timer
// Purpose  : Loadable down-counter that parks at zero; count_done flags zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hit_scan_timer #(
   parameter int WIDTH = 9
) (
   input  logic             clk40M,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic             count_done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk40M) begin
      if (reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_value;
      end else if (enable && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign count_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/hit_scan_sequencer.sv
// ============================================================================
// Module   : hit_scan_sequencer
// Purpose  : Steps a scan index, triggers the hit counter per step and streams
//            {step, count, flags}. Peak tracking under HIT_SCAN_PEAK_TRACK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hit_scan_sequencer
   import hit_scan_pkg::*;
#(
   parameter int NUM_STEPS     = 32,
   parameter int STEP_W        = 5,
   parameter int COUNT_W       = DEFAULT_COUNT_W,
   parameter int SETTLE_CYCLES = 400,
   parameter int START_HOLD    = 4,
   parameter int TIMEOUT_TICKS = 4
) (
   input  logic               clk40M,
   input  logic               reset,
   input  logic               scan_go,
   input  logic               scan_abort,
   input  logic               tick,
   output logic               stat_start,
   input  logic               stat_ready,
   input  logic [COUNT_W-1:0] stat_count,
   output logic [STEP_W-1:0]  step_idx,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [STEP_W-1:0]  res_step,
   output logic [COUNT_W-1:0] res_count,
   output logic [1:0]         res_flags,
`ifdef HIT_SCAN_PEAK_TRACK_EN
   output logic [COUNT_W-1:0] peak_count,
   output logic [STEP_W-1:0]  peak_step,
`endif
   output logic               busy,
   output logic               done
);

   localparam int c_SET_MAX = (SETTLE_CYCLES > START_HOLD) ? SETTLE_CYCLES : START_HOLD;
   localparam int c_SET_W   = $clog2(c_SET_MAX + 1);
   localparam int c_TO_W    = $clog2(TIMEOUT_TICKS + 1);

   // Timers are loaded with N-1 so the owning state lasts exactly N cycles/ticks.
   localparam logic [c_SET_W-1:0] c_SETTLE_LOAD = c_SET_W'(SETTLE_CYCLES - 1);
   localparam logic [c_SET_W-1:0] c_HOLD_LOAD   = c_SET_W'(START_HOLD - 1);
   localparam logic [c_TO_W-1:0]  c_TO_LOAD     = c_TO_W'(TIMEOUT_TICKS - 1);
   localparam logic [STEP_W-1:0]  c_LAST_STEP   = STEP_W'(NUM_STEPS - 1);
   localparam logic [COUNT_W-1:0] c_ALL_ONES    = '1;

   state_t               r_state;
   state_t               w_next;
   logic                 r_go_d;
   logic [STEP_W-1:0]    r_step;
   logic                 r_res_valid;
   logic [STEP_W-1:0]    r_res_step;
   logic [COUNT_W-1:0]   r_res_count;
   logic [1:0]           r_res_flags;
   logic                 r_done;

   logic                 w_go_rise;
   logic                 w_in_wait;
   logic                 w_expire;
   logic                 w_set_load;
   logic [c_SET_W-1:0]   w_set_value;
   logic                 w_set_en;
   logic                 w_set_done;
   logic                 w_to_load;
   logic                 w_to_en;
   logic                 w_to_done;
   logic                 w_capture;
   logic                 w_timeout;
   logic                 w_accept;
   logic                 w_scan_start;

   assign w_go_rise = scan_go && !r_go_d;
   assign w_in_wait = (r_state == ST_ARM_WAIT) || (r_state == ST_COUNT_WAIT);
   assign w_set_en  = (r_state == ST_SETTLE) || (r_state == ST_START);
   assign w_to_en   = tick && w_in_wait;
   // The tick that would take the remaining budget below zero is the expiring one.
   assign w_expire  = w_to_en && w_to_done;

   hit_scan_timer #(
      .WIDTH (c_SET_W)
   ) u_settle_timer (
      .clk40M     (clk40M),
      .reset      (reset),
      .load       (w_set_load),
      .load_value (w_set_value),
      .enable     (w_set_en),
      .count_done (w_set_done)
   );

   hit_scan_timer #(
      .WIDTH (c_TO_W)
   ) u_tick_timer (
      .clk40M     (clk40M),
      .reset      (reset),
      .load       (w_to_load),
      .load_value (c_TO_LOAD),
      .enable     (w_to_en),
      .count_done (w_to_done)
   );

   always_comb begin
      w_next       = r_state;
      w_set_load   = 1'b0;
      w_set_value  = c_SETTLE_LOAD;
      w_to_load    = 1'b0;
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      w_accept     = 1'b0;
      w_scan_start = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_go_rise) begin
               w_next       = ST_SETTLE;
               w_set_load   = 1'b1;
               w_scan_start = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (w_set_done) begin
               w_next      = ST_START;
               w_set_load  = 1'b1;
               w_set_value = c_HOLD_LOAD;
            end
         end
         ST_START: begin
            if (w_set_done) begin
               w_next    = ST_ARM_WAIT;
               w_to_load = 1'b1;
            end
         end
         ST_ARM_WAIT: begin
            if (w_expire) begin
               w_next    = ST_EMIT;
               w_timeout = 1'b1;
            end else if (!stat_ready) begin
               w_next = ST_COUNT_WAIT;
            end
         end
         ST_COUNT_WAIT: begin
            if (stat_ready) begin
               w_next    = ST_EMIT;
               w_capture = 1'b1;
            end else if (w_expire) begin
               w_next    = ST_EMIT;
               w_timeout = 1'b1;
            end
         end
         ST_EMIT: begin
            if (res_ready) begin
               w_accept = 1'b1;
               if (r_step == c_LAST_STEP) begin
                  w_next = ST_DONE;
               end else begin
                  w_next     = ST_SETTLE;
                  w_set_load = 1'b1;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
      if (scan_abort) begin
         w_next       = ST_IDLE;
         w_set_load   = 1'b0;
         w_to_load    = 1'b0;
         w_capture    = 1'b0;
         w_timeout    = 1'b0;
         w_accept     = 1'b0;
         w_scan_start = 1'b0;
      end
   end

   always_ff @(posedge clk40M) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_go_d      <= 1'b0;
         r_step      <= '0;
         r_res_valid <= 1'b0;
         r_res_step  <= '0;
         r_res_count <= '0;
         r_res_flags <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_go_d  <= scan_go;
         r_done  <= w_accept && (r_step == c_LAST_STEP);
         if (w_scan_start) begin
            r_step <= '0;
         end else if (w_accept && (r_step != c_LAST_STEP)) begin
            r_step <= r_step + STEP_W'(1);
         end
         if (w_capture) begin
            r_res_valid               <= 1'b1;
            r_res_step                <= r_step;
            r_res_count               <= stat_count;
            r_res_flags[FLAG_TIMEOUT] <= 1'b0;
            r_res_flags[FLAG_SAT]     <= (stat_count == c_ALL_ONES);
         end else if (w_timeout) begin
            r_res_valid               <= 1'b1;
            r_res_step                <= r_step;
            r_res_count               <= '0;
            r_res_flags[FLAG_TIMEOUT] <= 1'b1;
            r_res_flags[FLAG_SAT]     <= 1'b0;
         end else if (w_accept || scan_abort) begin
            r_res_valid <= 1'b0;
         end
      end
   end

`ifdef HIT_SCAN_PEAK_TRACK_EN
   logic [COUNT_W-1:0] r_peak_count;
   logic [STEP_W-1:0]  r_peak_step;

   // Strict compare keeps the earliest step on ties.
   always_ff @(posedge clk40M) begin
      if (reset || w_scan_start) begin
         r_peak_count <= '0;
         r_peak_step  <= '0;
      end else if (w_accept && !r_res_flags[FLAG_TIMEOUT] && (r_res_count > r_peak_count)) begin
         r_peak_count <= r_res_count;
         r_peak_step  <= r_res_step;
      end
   end

   assign peak_count = r_peak_count;
   assign peak_step  = r_peak_step;
`endif

   assign stat_start = (r_state == ST_START);
   assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign step_idx   = r_step;
   assign res_valid  = r_res_valid;
   assign res_step   = r_res_step;
   assign res_count  = r_res_count;
   assign res_flags  = r_res_flags;
   assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hit_scan_sequencer.sv
// ============================================================================
// Module   : tb_hit_scan_sequencer
// Purpose  : Scoreboard bench for hit_scan_sequencer with a behavioural hit counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hit_scan_sequencer;

   localparam int NUM_STEPS     = 4;
   localparam int STEP_W        = 5;
   localparam int COUNT_W       = 20;
   localparam int SETTLE_CYCLES = 10;
   localparam int START_HOLD    = 4;
   localparam int TIMEOUT_TICKS = 4;

   typedef struct packed {
      logic [STEP_W-1:0]  step;
      logic [COUNT_W-1:0] count;
      logic [1:0]         flags;
   } res_t;

   logic               clk40M = 1'b0;
   logic               reset;
   logic               scan_go;
   logic               scan_abort;
   logic               tick;
   logic               stat_start;
   logic               stat_ready;
   logic [COUNT_W-1:0] stat_count;
   logic [STEP_W-1:0]  step_idx;
   logic               res_valid;
   logic               res_ready;
   logic [STEP_W-1:0]  res_step;
   logic [COUNT_W-1:0] res_count;
   logic [1:0]         res_flags;
   logic               busy;
   logic               done;
`ifdef HIT_SCAN_PEAK_TRACK_EN
   logic [COUNT_W-1:0] peak_count;
   logic [STEP_W-1:0]  peak_step;
`endif

   always #5 clk40M = ~clk40M;

   hit_scan_sequencer #(
      .NUM_STEPS     (NUM_STEPS),
      .STEP_W        (STEP_W),
      .COUNT_W       (COUNT_W),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .START_HOLD    (START_HOLD),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) dut (
      .clk40M     (clk40M),
      .reset      (reset),
      .scan_go    (scan_go),
      .scan_abort (scan_abort),
      .tick       (tick),
      .stat_start (stat_start),
      .stat_ready (stat_ready),
      .stat_count (stat_count),
      .step_idx   (step_idx),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_step   (res_step),
      .res_count  (res_count),
      .res_flags  (res_flags),
`ifdef HIT_SCAN_PEAK_TRACK_EN
      .peak_count (peak_count),
      .peak_step  (peak_step),
`endif
      .busy       (busy),
      .done       (done)
   );

   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   res_t exp_q[$];

   // Hit counter model: stale ready lingers stale_cycles after the start edge,
   // then ready drops; six cycles later the step's count appears with ready.
   logic [COUNT_W-1:0] tbl [NUM_STEPS];
   logic               never_rdy [NUM_STEPS];
   int                 stale_cycles = 2;
   logic               start_d;
   int                 m_phase;
   int                 m_cnt;
   logic [1:0]         m_step;

   always @(posedge clk40M) begin
      start_d <= stat_start;
      if (reset) begin
         stat_ready <= 1'b0;
         stat_count <= '0;
         m_phase    <= 0;
         m_cnt      <= 0;
         m_step     <= '0;
      end else if (stat_start && !start_d) begin
         m_phase    <= 1;
         m_cnt      <= 1;
         m_step     <= step_idx[1:0];
         stat_count <= 20'd12345;
      end else if (m_phase == 1) begin
         if (m_cnt >= stale_cycles) begin
            stat_ready <= 1'b0;
            m_phase    <= 2;
            m_cnt      <= 1;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end else if (m_phase == 2) begin
         if (m_cnt >= 6 && !never_rdy[m_step]) begin
            stat_ready <= 1'b1;
            stat_count <= tbl[m_step];
            m_phase    <= 0;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   int tc = 0;
   initial tick = 1'b0;
   always @(posedge clk40M) begin
      tc   <= (tc == 7) ? 0 : tc + 1;
      tick <= (tc == 7);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h required=%0h", name, got, want);
      end
   endtask

   // Monitor: every accepted result is matched against the oldest expectation.
   initial begin
      res_t e;
      forever begin
         @(negedge clk40M);
         if (!reset) begin
            if (done) done_cnt++;
            if (res_valid && res_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_result: got step=%0d count=%0h flags=%0b required=none",
                           res_step, res_count, res_flags);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("result_step%0d", e.step), 64'({res_step, res_count, res_flags}), 64'(e));
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk40M);
      #1;
   endtask

   task automatic push(input int step, input logic [COUNT_W-1:0] count, input logic [1:0] flags);
      res_t e;
      e.step  = STEP_W'(step);
      e.count = count;
      e.flags = flags;
      exp_q.push_back(e);
   endtask

   task automatic set_tbl(input logic [COUNT_W-1:0] a, b, c, d);
      tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
   endtask

   task automatic pulse_go();
      scan_go = 1'b1;
      cyc(2);
      scan_go = 1'b0;
      cyc(1);
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(negedge clk40M);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got=no done required=done within 3000 cycles", name);
      end
      cyc(5);
   endtask

   task automatic run_scan(input string name);
      int d0;
      d0 = done_cnt;
      pulse_go();
      wait_done(name);
      check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
      check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_stat_start"}, 64'(stat_start), 64'd0);
      check({name, "_step_idx"}, 64'(step_idx), 64'd0);
      check({name, "_res_valid"}, 64'(res_valid), 64'd0);
      check({name, "_res_fields"}, 64'({res_step, res_count, res_flags}), 64'd0);
      check({name, "_busy_done"}, 64'({busy, done}), 64'd0);
   endtask

   initial begin
      int   d0;
      bit   seen;
      bit   stable;
      bit   quiet;
      logic [27:0] snap;

      reset      = 1'b1;
      scan_go    = 1'b0;
      scan_abort = 1'b0;
      res_ready  = 1'b1;
      for (int i = 0; i < NUM_STEPS; i++) never_rdy[i] = 1'b0;
      set_tbl(20'd0, 20'd0, 20'd0, 20'd0);
      cyc(4);
      check_zero_outputs("reset");
      reset = 1'b0;
      cyc(2);

      // Basic scan: count = step*100
      set_tbl(20'd0, 20'd100, 20'd200, 20'd300);
      push(0, 20'd0, 2'b00); push(1, 20'd100, 2'b00);
      push(2, 20'd200, 2'b00); push(3, 20'd300, 2'b00);
      run_scan("basic");
      check("basic_final_step", 64'(step_idx), 64'd3);
      check("basic_not_busy", 64'(busy), 64'd0);

      // Stale ready lingers into ARM_WAIT with a junk count on the bus
      stale_cycles = 8;
      set_tbl(20'd7, 20'd8, 20'd9, 20'd10);
      push(0, 20'd7, 2'b00); push(1, 20'd8, 2'b00);
      push(2, 20'd9, 2'b00); push(3, 20'd10, 2'b00);
      run_scan("stale");
      stale_cycles = 2;

      // Step 1 never becomes ready
      never_rdy[1] = 1'b1;
      set_tbl(20'd11, 20'd22, 20'd33, 20'd44);
      push(0, 20'd11, 2'b00); push(1, 20'd0, 2'b01);
      push(2, 20'd33, 2'b00); push(3, 20'd44, 2'b00);
      run_scan("timeout");
      never_rdy[1] = 1'b0;

      // Saturated count under 50 cycles of backpressure
      set_tbl(20'hFFFFF, 20'd1, 20'd2, 20'd3);
      push(0, 20'hFFFFF, 2'b10); push(1, 20'd1, 2'b00);
      push(2, 20'd2, 2'b00); push(3, 20'd3, 2'b00);
      res_ready = 1'b0;
      d0 = done_cnt;
      pulse_go();
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge clk40M);
         if (res_valid) seen = 1'b1;
      end
      check("stall_valid_seen", 64'(seen), 64'd1);
      snap = {res_valid, res_step, res_count, res_flags};
      stable = 1'b1;
      quiet = 1'b1;
      repeat (50) begin
         @(negedge clk40M);
         if ({res_valid, res_step, res_count, res_flags} !== snap) stable = 1'b0;
         if (stat_start !== 1'b0 || step_idx !== '0) quiet = 1'b0;
      end
      check("stall_res_stable", 64'(stable), 64'd1);
      check("stall_no_start_no_step", 64'(quiet), 64'd1);
      check("stall_sat_count", 64'(res_count), 64'hFFFFF);
      check("stall_sat_flags", 64'(res_flags), 64'd2);
      @(posedge clk40M);
      #1;
      res_ready = 1'b1;
      wait_done("stall");
      check("stall_done_pulses", 64'(done_cnt - d0), 64'd1);
      check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

      // Abort while waiting for the count at step 2
      never_rdy[2] = 1'b1;
      set_tbl(20'd5, 20'd6, 20'd7, 20'd8);
      push(0, 20'd5, 2'b00); push(1, 20'd6, 2'b00);
      d0 = done_cnt;
      pulse_go();
      seen = 1'b0;
      for (int k = 0; k < 1000 && !seen; k++) begin
         @(negedge clk40M);
         if (step_idx == 2 && stat_start) seen = 1'b1;
      end
      check("abort_reached_step2", 64'(seen), 64'd1);
      for (int k = 0; k < 20 && stat_start; k++) @(negedge clk40M);
      cyc(8);
      scan_abort = 1'b1;
      cyc(1);
      scan_abort = 1'b0;
      check("abort_idle", 64'({busy, res_valid, stat_start}), 64'd0);
      check("abort_step_kept", 64'(step_idx), 64'd2);
      cyc(60);
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
      never_rdy[2] = 1'b0;

      // Restart, then reset during SETTLE
      pulse_go();
      check("restart_settle_busy", 64'(busy), 64'd1);
      check("restart_step0", 64'(step_idx), 64'd0);
      reset = 1'b1;
      cyc(2);
      check_zero_outputs("midreset");
      reset = 1'b0;
      cyc(2);
      push(0, 20'd5, 2'b00); push(1, 20'd6, 2'b00);
      push(2, 20'd7, 2'b00); push(3, 20'd8, 2'b00);
      run_scan("after_reset");

`ifdef HIT_SCAN_PEAK_TRACK_EN
      set_tbl(20'd50, 20'd300, 20'd300, 20'd10);
      push(0, 20'd50, 2'b00); push(1, 20'd300, 2'b00);
      push(2, 20'd300, 2'b00); push(3, 20'd10, 2'b00);
      run_scan("peak");
      check("peak_count", 64'(peak_count), 64'd300);
      check("peak_step", 64'(peak_step), 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
